// File: rtl/uart_tx_frame_pkg.sv
// Shared types for the UART transmit framer.
// The PARITY state is only reachable when UART_TX_FRAME_PARITY_EN is defined.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of a DATA_WIDTH word; odd parity is the inverse of the XOR.
// Instantiated by uart_tx_frame only when UART_TX_FRAME_PARITY_EN is defined.
module uart_parity_calc
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);

  assign par = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_FRAME_PARITY_EN to add the PAR_EN/PAR_TYP ports and the parity bit.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  REF_CLK,
  input  logic                  RST_REF,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VLD,
`ifdef UART_TX_FRAME_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                state, next_state;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  bit_end, last_bit, capture;
  logic                  send_par, par_tx;
  logic                  tx_d, busy_d, done_d;

  assign bit_end  = (cnt == CNT_W'(PRESCALE - 1));
  assign last_bit = (idx == IDX_W'(DATA_WIDTH - 1));
  assign capture  = (state == IDLE) && DATA_VLD;

`ifdef UART_TX_FRAME_PARITY_EN
  logic par_calc, par_en_q, par_bit_q;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par     (par_calc)
  );

  // Parity is frozen at capture so later P_DATA/PAR_TYP changes cannot alter the frame.
  always_ff @(posedge REF_CLK) begin
    if (RST_REF) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (capture) begin
      par_en_q  <= PAR_EN;
      par_bit_q <= par_calc;
    end
  end

  assign send_par = par_en_q;
  assign par_tx   = par_bit_q;
`else
  assign send_par = 1'b0;
  assign par_tx   = 1'b0;
`endif

  // NOTE: data_q is a pure datapath register that is always written before it is
  // read, so it carries no reset; only control state needs a defined reset value.
  always_ff @(posedge REF_CLK) begin
    if (capture) data_q <= P_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge REF_CLK) begin
    if (RST_REF) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    idx_next   = idx;
    if (state == IDLE) begin
      cnt_next = '0;
      idx_next = '0;
      if (DATA_VLD) next_state = START;
    end else if (bit_end) begin
      cnt_next = '0;
      case (state)
        START:  next_state = DATA;
        DATA: begin
          if (last_bit) begin
            idx_next   = '0;
            next_state = send_par ? PARITY : STOP;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
        PARITY: next_state = STOP;
        STOP:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so the registered line changes on the
  // same edge the state does.
  always_comb begin
    tx_d = 1'b1;
    case (next_state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_next];
      PARITY:  tx_d = par_tx;
      default: tx_d = 1'b1;
    endcase
    busy_d = (next_state != IDLE);
    done_d = (state == STOP) && bit_end;
  end

  always_ff @(posedge REF_CLK) begin
    if (RST_REF) begin
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      TX_OUT <= tx_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one instance at PRESCALE=4, one at PRESCALE=1,
// sharing stimulus. Parity vectors apply when UART_TX_FRAME_PARITY_EN is defined.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pd  = 8'h00;
  logic       dv  = 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
  logic       pe  = 1'b0;
  logic       pt  = 1'b0;
`endif
  logic tx4, busy4, done4, tx1, busy1, done1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(4)) u_dut4 (
    .REF_CLK  (clk),
    .RST_REF  (rst),
    .P_DATA   (pd),
    .DATA_VLD (dv),
`ifdef UART_TX_FRAME_PARITY_EN
    .PAR_EN   (pe),
    .PAR_TYP  (pt),
`endif
    .TX_OUT   (tx4),
    .BUSY     (busy4),
    .DONE     (done4)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(1)) u_dut1 (
    .REF_CLK  (clk),
    .RST_REF  (rst),
    .P_DATA   (pd),
    .DATA_VLD (dv),
`ifdef UART_TX_FRAME_PARITY_EN
    .PAR_EN   (pe),
    .PAR_TYP  (pt),
`endif
    .TX_OUT   (tx1),
    .BUSY     (busy1),
    .DONE     (done1)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Sends one word and checks every line cycle. exp_bits[i] is the i-th serial bit.
  // keep_vld leaves DATA_VLD high with P_DATA=next_data after capture; cycles
  // bad_lo..bad_hi of the frame present DATA_VLD=1 with 0x55 to the busy DUT.
  task automatic send_frame(input string tag, input int ps, input logic [7:0] data,
                            input logic [15:0] exp_bits, input int nbits,
                            input bit keep_vld, input logic [7:0] next_data,
                            input int bad_lo, input int bad_hi);
    pd = data;
    dv = 1'b1;
    step();
    if (keep_vld) pd = next_data;
    else dv = 1'b0;
    for (int j = 0; j < nbits * ps; j++) begin
      check({tag, "_tx"},   (ps == 1) ? tx1   : tx4,   exp_bits[j / ps]);
      check({tag, "_busy"}, (ps == 1) ? busy1 : busy4, 1'b1);
      check({tag, "_done"}, (ps == 1) ? done1 : done4, 1'b0);
      if (!keep_vld) begin
        if (j >= bad_lo && j <= bad_hi) begin
          dv = 1'b1;
          pd = 8'h55;
        end else begin
          dv = 1'b0;
        end
      end
      step();
    end
    check({tag, "_end_done"}, (ps == 1) ? done1 : done4, 1'b1);
    check({tag, "_end_busy"}, (ps == 1) ? busy1 : busy4, 1'b0);
    check({tag, "_end_tx"},   (ps == 1) ? tx1   : tx4,   1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;

    do_reset();
    check("rst_tx4",   tx4,   1'b1);
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_tx1",   tx1,   1'b1);
    check("rst_busy1", busy1, 1'b0);
    check("rst_done1", done1, 1'b0);

    // No parity, 0xFF at PRESCALE=4: 40-cycle frame, stop right after bit 7.
`ifdef UART_TX_FRAME_PARITY_EN
    pe = 1'b0;
    pt = 1'b0;
`endif
    send_frame("nopar_ff", 4, 8'hFF, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 8'h00, -1, -1);
    step();
    check("nopar_done_pulse", done4, 1'b0);

    // 0xA5 at PRESCALE=4; even parity of 0xA5 is 0, 44-cycle frame.
    do_reset();
`ifdef UART_TX_FRAME_PARITY_EN
    pe = 1'b1;
    pt = 1'b0;
    send_frame("even_a5", 4, 8'hA5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 8'h00, -1, -1);
`else
    send_frame("plain_a5", 4, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'h00, -1, -1);
`endif

    // 0x01 at PRESCALE=1; odd parity of 0x01 is 0, 11-cycle frame.
    do_reset();
`ifdef UART_TX_FRAME_PARITY_EN
    pe = 1'b1;
    pt = 1'b1;
    send_frame("odd_01", 1, 8'h01, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 1'b0, 8'h00, -1, -1);
`else
    send_frame("plain_01", 1, 8'h01, {6'b0, 1'b1, 8'h01, 1'b0}, 10, 1'b0, 8'h00, -1, -1);
`endif
    step();
    check("ps1_done_pulse", done1, 1'b0);

    // 0x55 offered during the DATA state of an 0xA5 frame must be dropped.
    do_reset();
`ifdef UART_TX_FRAME_PARITY_EN
    pe = 1'b0;
`endif
    send_frame("busy_ign", 4, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 8'h00, 12, 20);
    for (int i = 0; i < 8; i++) begin
      check("busy_ign_idle_tx",   tx4,   1'b1);
      check("busy_ign_idle_busy", busy4, 1'b0);
      step();
    end

    // Reset 10 cycles into a 0x3C frame aborts it without a DONE pulse.
    do_reset();
    pd = 8'h3C;
    dv = 1'b1;
    step();
    dv = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_tx",   tx4,   1'b1);
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    seen_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done4 || busy4 || !tx4) seen_done = 1'b1;
      step();
    end
    check("abort_quiet", seen_done, 1'b0);
    send_frame("after_abort", 4, 8'h3C, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 8'h00, -1, -1);

    // DATA_VLD held high: 0x12 then 0x34, second capture on the DONE cycle.
    do_reset();
    send_frame("b2b_12", 4, 8'h12, {6'b0, 1'b1, 8'h12, 1'b0}, 10, 1'b1, 8'h34, -1, -1);
    send_frame("b2b_34", 4, 8'h34, {6'b0, 1'b1, 8'h34, 1'b0}, 10, 1'b0, 8'h00, -1, -1);
    step();
    check("b2b_idle_tx",   tx4,   1'b1);
    check("b2b_idle_done", done4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
